// File: rtl/dac_serial_rx.sv
// Serial-to-parallel receiver for the DAC serial link: one frame per DAC_scen low
// window (DWIDTH data bits LSB first, address bit, guard bit), two channel registers.
module dac_serial_rx #(
  parameter int unsigned DWIDTH = 8
) (
  input  logic              clk_4M,
  input  logic              rst_n,
  input  logic              DAC_scen,
  input  logic              sdin,
  output logic [DWIDTH-1:0] data,
  output logic              addr,
  output logic [DWIDTH-1:0] dout_a,
  output logic [DWIDTH-1:0] dout_b,
  output logic              valid,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned FW = DWIDTH + 2;
  localparam int unsigned CW = $clog2(FW) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [FW-1:0] sh, sh_nx, word_c;
  logic          load_c, valid_nx, err_nx;

  // Right shift with the new bit entering at the MSB.
  assign word_c = (sh >> 1) | (FW'(sdin) << (FW - 1));

  // State register
  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and datapath control
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sh_nx    = sh;
    load_c   = 1'b0;
    valid_nx = 1'b0;
    err_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!DAC_scen) begin
          sh_nx    = word_c;
          cnt_nx   = CW'(1);
          state_nx = S_RECV;
        end
      end
      S_RECV: begin
        if (DAC_scen) begin
          err_nx   = 1'b1;
          cnt_nx   = '0;
          state_nx = S_IDLE;
        end else if (cnt == CW'(FW - 1)) begin
          // Guard bit edge: the assembled word is complete in word_c.
          sh_nx    = word_c;
          cnt_nx   = '0;
          state_nx = S_DONE;
          if (word_c[FW-1]) begin
            load_c   = 1'b1;
            valid_nx = 1'b1;
          end else begin
            err_nx   = 1'b1;
          end
        end else begin
          sh_nx  = word_c;
          cnt_nx = cnt + CW'(1);
        end
      end
      S_DONE: begin
        if (DAC_scen) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Shift register, counter, output registers and pulses
  always_ff @(posedge clk_4M or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      sh        <= '0;
      data      <= '0;
      addr      <= 1'b0;
      dout_a    <= '0;
      dout_b    <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cnt       <= cnt_nx;
      sh        <= sh_nx;
      valid     <= valid_nx;
      frame_err <= err_nx;
      busy      <= (state_nx == S_RECV);
      if (load_c) begin
        data <= word_c[DWIDTH-1:0];
        addr <= word_c[DWIDTH];
        if (word_c[DWIDTH]) dout_b <= word_c[DWIDTH-1:0];
        else                dout_a <= word_c[DWIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_dac_serial_rx.sv
// Bench for dac_serial_rx: directed frames plus random frames/aborts/long windows,
// every cycle compared against a bit-array frame model.
module tb_dac_serial_rx;

  localparam int unsigned DW = 8;
  localparam int unsigned FL = DW + 2;

  logic          clk_4M = 1'b0;
  logic          rst_n;
  logic          DAC_scen;
  logic          sdin;
  logic [DW-1:0] data, dout_a, dout_b;
  logic          addr, valid, frame_err, busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          lowcnt;
  logic [FL-1:0] word;
  logic [DW-1:0] e_data, e_a, e_b;
  logic          e_addr, e_valid, e_err, e_busy;

  dac_serial_rx #(.DWIDTH(DW)) dut (
    .clk_4M(clk_4M), .rst_n(rst_n), .DAC_scen(DAC_scen), .sdin(sdin),
    .data(data), .addr(addr), .dout_a(dout_a), .dout_b(dout_b),
    .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk_4M = ~clk_4M;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    lowcnt = 0; word = '0;
    e_data = '0; e_a = '0; e_b = '0;
    e_addr = 1'b0; e_valid = 1'b0; e_err = 1'b0; e_busy = 1'b0;
  endtask

  task automatic check_all();
    chk("data",      32'(data),      32'(e_data));
    chk("addr",      32'(addr),      32'(e_addr));
    chk("dout_a",    32'(dout_a),    32'(e_a));
    chk("dout_b",    32'(dout_b),    32'(e_b));
    chk("valid",     32'(valid),     32'(e_valid));
    chk("frame_err", 32'(frame_err), 32'(e_err));
    chk("busy",      32'(busy),      32'(e_busy));
  endtask

  // Model of one sampled edge: count low edges, collect bits, judge the frame
  // when the window reaches FL bits; an early rise rejects a partial frame.
  task automatic model_edge(input logic scen, input logic bit_in);
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (scen) begin
      if (lowcnt > 0 && lowcnt < FL) e_err = 1'b1;
      lowcnt = 0;
    end else if (lowcnt < FL) begin
      word[lowcnt] = bit_in;
      lowcnt++;
      if (lowcnt == FL) begin
        if (word[FL-1]) begin
          e_data  = word[DW-1:0];
          e_addr  = word[DW];
          if (word[DW]) e_b = word[DW-1:0];
          else          e_a = word[DW-1:0];
          e_valid = 1'b1;
        end else begin
          e_err = 1'b1;
        end
      end
    end
    e_busy = (lowcnt > 0 && lowcnt < FL);
  endtask

  // Called at a falling edge: drive, clock, then compare at the next falling edge.
  task automatic cycle(input logic scen, input logic bit_in);
    DAC_scen = scen;
    sdin     = bit_in;
    @(posedge clk_4M);
    model_edge(scen, bit_in);
    @(negedge clk_4M);
    check_all();
  endtask

  task automatic send_bits(input logic [FL-1:0] w, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, w[i]);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic a, input logic g,
                            input int extra_low, input int gap);
    send_bits({g, a, d}, FL);
    for (int i = 0; i < extra_low; i++) cycle(1'b0, 1'($urandom));
    for (int i = 0; i < gap; i++) cycle(1'b1, 1'($urandom));
  endtask

  initial begin
    int vcount;
    int kind;
    rst_n = 1'b0; DAC_scen = 1'b1; sdin = 1'b0;
    model_reset();
    #2;
    check_all();
    repeat (2) @(posedge clk_4M);
    @(negedge clk_4M);
    rst_n = 1'b1;
    cycle(1'b1, 1'b0);

    // Directed frames
    send_frame(8'hA5, 1'b0, 1'b1, 0, 1);
    chk("tp1_dout_a", 32'(dout_a), 32'h0000_00A5);
    chk("tp1_dout_b", 32'(dout_b), 32'h0);
    send_frame(8'h3C, 1'b1, 1'b1, 0, 2);
    chk("tp2_dout_b", 32'(dout_b), 32'h0000_003C);
    chk("tp2_addr",   32'(addr),   32'h1);
    send_frame(8'hFF, 1'b0, 1'b0, 0, 2);
    chk("tp3_dout_a", 32'(dout_a), 32'h0000_00A5);

    // Early abort after 5 bits, then a clean frame
    send_bits({2'b10, 8'h77}, 5);
    cycle(1'b1, 1'b1);
    chk("tp4_err",  32'(frame_err), 32'h1);
    chk("tp4_busy", 32'(busy),      32'h0);
    send_frame(8'h11, 1'b0, 1'b1, 0, 1);
    chk("tp4_dout_a", 32'(dout_a), 32'h0000_0011);

    // Long low window: exactly one valid
    vcount = 0;
    send_bits({2'b11, 8'h5A}, FL);
    if (valid) vcount++;
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 1'($urandom));
      if (valid) vcount++;
    end
    cycle(1'b1, 1'b0);
    chk("tp5_valid_count", 32'(vcount), 32'h1);
    chk("tp5_dout_b", 32'(dout_b), 32'h0000_005A);

    // Back-to-back frames with a single high cycle
    send_frame(8'h96, 1'b0, 1'b1, 0, 1);
    send_frame(8'h69, 1'b1, 1'b1, 0, 1);
    chk("tp6_dout_a", 32'(dout_a), 32'h0000_0096);
    chk("tp6_dout_b", 32'(dout_b), 32'h0000_0069);

    // Reset at bit 4 of a frame
    send_bits({2'b11, 8'hC3}, 4);
    rst_n = 1'b0;
    DAC_scen = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk_4M);
    @(negedge clk_4M);
    check_all();
    rst_n = 1'b1;
    send_frame(8'h42, 1'b1, 1'b1, 0, 1);
    chk("tp7_dout_b", 32'(dout_b), 32'h0000_0042);
    chk("tp7_dout_a", 32'(dout_a), 32'h0);

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 2) begin
        send_bits(FL'($urandom), int'($urandom_range(1, FL - 1)));
        for (int i = 0; i < int'($urandom_range(1, 3)); i++) cycle(1'b1, 1'($urandom));
      end else begin
        send_frame(DW'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0),
                   (kind == 9) ? 15 : int'($urandom_range(0, 3)),
                   int'($urandom_range(1, 3)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
